// File: rtl/mul_pkg.sv
// Shared sizing helpers for the pipelined multiplier.
package mul_pkg;
   localparam int ACC_GUARD = 8;

   function automatic int prod_w(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction
endpackage

// File: rtl/mul_pipe_stage.sv
// One pipeline register (valid + product) that holds its contents while hold is high.
module mul_pipe_stage
   import mul_pkg::*;
#(
   parameter int P_W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           hold,
   input  logic           d_vld,
   input  logic [P_W-1:0] d_prod,
   output logic           q_vld,
   output logic [P_W-1:0] q_prod
);
   typedef struct packed {
      logic           vld;
      logic [P_W-1:0] prod;
   } stage_t;

   stage_t q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (!hold)
         q <= '{vld: d_vld, prod: d_prod};
   end

   assign q_vld  = q.vld;
   assign q_prod = q.prod;
endmodule

// File: rtl/pipelined_multiplier.sv
// Pipelined unsigned multiplier feeding a write FIFO; a full FIFO freezes the whole pipe.
// Optional running accumulator of written products when MUL_ACC_EN is defined.
module pipelined_multiplier
   import mul_pkg::*;
#(
   parameter int A_W    = 4,
   parameter int B_W    = 4,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic                 Wclk,
   input  logic                 Wrst_n,
   input  logic [A_W-1:0]       a_i,
   input  logic [B_W-1:0]       b_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic                 Wfull_i,
   output logic                 Wen_o,
   output logic [A_W+B_W-1:0]   Mul_o,
   output logic                 Mul_valid_o,
   output logic [CNT_W-1:0]     wr_count_o
`ifdef MUL_ACC_EN
   ,
   input  logic                 acc_clr_i,
   output logic [A_W+B_W+ACC_GUARD-1:0] Acc_o
`endif
);
   localparam int P_W = prod_w(A_W, B_W);

   logic                          stall;
   logic                          in_vld;
   logic [P_W-1:0]                in_prod;
   logic [STAGES-1:0]             vld_pipe;
   logic [STAGES-1:0][P_W-1:0]    prod_pipe;

   // Stall only when a real product is blocked; bubbles at the output never stall.
   assign stall   = Mul_valid_o & Wfull_i;
   assign ready_o = ~stall;
   assign in_vld  = valid_i & ready_o;
   assign in_prod = in_vld ? P_W'(a_i) * P_W'(b_i) : '0;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
         mul_pipe_stage #(.P_W(P_W)) u_stage (
            .clk(Wclk), .rst_n(Wrst_n), .hold(stall),
            .d_vld(in_vld), .d_prod(in_prod),
            .q_vld(vld_pipe[s]), .q_prod(prod_pipe[s])
         );
      end else begin : g_rest
         mul_pipe_stage #(.P_W(P_W)) u_stage (
            .clk(Wclk), .rst_n(Wrst_n), .hold(stall),
            .d_vld(vld_pipe[s-1]), .d_prod(prod_pipe[s-1]),
            .q_vld(vld_pipe[s]), .q_prod(prod_pipe[s])
         );
      end
   end

   assign Mul_valid_o = vld_pipe[STAGES-1];
   assign Mul_o       = prod_pipe[STAGES-1];
   assign Wen_o       = Mul_valid_o & ~Wfull_i;

   always_ff @(posedge Wclk or negedge Wrst_n) begin
      if (!Wrst_n)
         wr_count_o <= '0;
      else if (Wen_o)
         wr_count_o <= wr_count_o + CNT_W'(1);
   end

`ifdef MUL_ACC_EN
   localparam int ACC_W = P_W + ACC_GUARD;

   // Clear wins over the old sum but still picks up a product written the same cycle.
   always_ff @(posedge Wclk or negedge Wrst_n) begin
      if (!Wrst_n)
         Acc_o <= '0;
      else if (acc_clr_i)
         Acc_o <= Wen_o ? ACC_W'(Mul_o) : '0;
      else if (Wen_o)
         Acc_o <= Acc_o + ACC_W'(Mul_o);
   end
`endif
endmodule

// File: tb/tb_pipelined_multiplier.sv
// Randomised and directed bench for pipelined_multiplier against a queue-based product model.
module tb_pipelined_multiplier;
   localparam int ST  = 2;
   localparam int ST2 = 3;

   logic Wclk = 1'b0;
   logic Wrst_n = 1'b1;
   always #5 Wclk = ~Wclk;

   logic [3:0]  a_i, b_i;
   logic        valid_i, ready_o, Wfull_i, Wen_o, Mul_valid_o;
   logic [7:0]  Mul_o;
   logic [15:0] wr_count_o;
   logic [7:0]  a2;
   logic [5:0]  b2;
   logic        v2, r2, f2, w2, mv2;
   logic [13:0] m2;
   logic [3:0]  c2;
`ifdef MUL_ACC_EN
   logic        acc_clr_i, acc2_clr;
   logic [15:0] Acc_o, acc_m;
   logic [21:0] acc2;
`endif

   pipelined_multiplier #(.A_W(4), .B_W(4), .STAGES(ST), .CNT_W(16)) dut (
      .Wclk(Wclk), .Wrst_n(Wrst_n), .a_i(a_i), .b_i(b_i), .valid_i(valid_i),
      .ready_o(ready_o), .Wfull_i(Wfull_i), .Wen_o(Wen_o), .Mul_o(Mul_o),
      .Mul_valid_o(Mul_valid_o), .wr_count_o(wr_count_o)
`ifdef MUL_ACC_EN
      , .acc_clr_i(acc_clr_i), .Acc_o(Acc_o)
`endif
   );

   pipelined_multiplier #(.A_W(8), .B_W(6), .STAGES(ST2), .CNT_W(4)) dut2 (
      .Wclk(Wclk), .Wrst_n(Wrst_n), .a_i(a2), .b_i(b2), .valid_i(v2),
      .ready_o(r2), .Wfull_i(f2), .Wen_o(w2), .Mul_o(m2),
      .Mul_valid_o(mv2), .wr_count_o(c2)
`ifdef MUL_ACC_EN
      , .acc_clr_i(acc2_clr), .Acc_o(acc2)
`endif
   );

   int n_cmp = 0, n_bad = 0;
   int q[$], q2[$];
   int nwr = 0, nwr2 = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference: every accepted pair is owed exactly one write of a*b, in order.
   always @(negedge Wclk) begin
      if (!Wrst_n) begin
         q.delete();
         q2.delete();
`ifdef MUL_ACC_EN
         acc_m <= '0;
`endif
      end else begin
         chk("ready", 64'(ready_o), 64'(!(Mul_valid_o && Wfull_i)));
         chk("wen", 64'(Wen_o), 64'(Mul_valid_o && !Wfull_i));
         if (Wen_o) begin
            nwr <= nwr + 1;
            if (q.size() == 0) chk("wen_extra", 64'(Wen_o), 64'(0));
            else chk("prod", 64'(Mul_o), 64'(q.pop_front()));
         end
         if (valid_i && ready_o) q.push_back(int'(a_i) * int'(b_i));
         if (w2) begin
            nwr2 <= nwr2 + 1;
            if (q2.size() == 0) chk("wen2_extra", 64'(w2), 64'(0));
            else chk("prod2", 64'(m2), 64'(q2.pop_front()));
         end
         if (v2 && r2) q2.push_back(int'(a2) * int'(b2));
`ifdef MUL_ACC_EN
         chk("acc", 64'(Acc_o), 64'(acc_m));
         if (acc_clr_i) acc_m <= Wen_o ? 16'(Mul_o) : 16'(0);
         else if (Wen_o) acc_m <= acc_m + 16'(Mul_o);
`endif
      end
   end

   task automatic send(input logic [3:0] a, input logic [3:0] b);
      bit t = 1'b0;
      a_i = a; b_i = b; valid_i = 1'b1;
      for (int k = 0; k < 200 && !t; k++) begin
         @(negedge Wclk);
         t = valid_i && ready_o;
         @(posedge Wclk); #1;
      end
      chk("send_accept", 64'(t), 64'(1));
      valid_i = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      valid_i = 1'b0; Wfull_i = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge Wclk);
         done = (q.size() == 0) && !Mul_valid_o;
      end
      chk("drain", 64'(done), 64'(1));
      @(posedge Wclk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit hit, pend, seen;
      int base;
      valid_i = 0; a_i = 0; b_i = 0; Wfull_i = 0;
      v2 = 0; a2 = 0; b2 = 0; f2 = 0;
`ifdef MUL_ACC_EN
      acc_clr_i = 0; acc2_clr = 0;
`endif
      #2 Wrst_n = 1'b0;
      #1;
      chk("rst_mul", 64'(Mul_o), 64'(0));
      chk("rst_mvld", 64'(Mul_valid_o), 64'(0));
      chk("rst_wen", 64'(Wen_o), 64'(0));
      chk("rst_cnt", 64'(wr_count_o), 64'(0));
      chk("rst_ready", 64'(ready_o), 64'(1));
      chk("rst_mul2", 64'(m2), 64'(0));
      repeat (2) @(posedge Wclk);
      #1 Wrst_n = 1'b1;

      // Exhaustive 4x4, back to back, no backpressure
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            send(4'(a), 4'(b));
      drain();
      chk("cnt_256", 64'(wr_count_o), 64'(256));

      // Backpressure: freeze with 15 at the output for 10 cycles
      base = nwr; hit = 0;
      fork
         begin send(3, 5); send(7, 9); send(15, 15); end
         begin
            for (int k = 0; k < 40 && !hit; k++) begin
               @(posedge Wclk); #1;
               hit = Mul_valid_o && (Mul_o == 8'd15);
            end
            chk("bp_hit", 64'(hit), 64'(1));
            if (hit) begin
               Wfull_i = 1'b1;
               for (int k = 0; k < 10; k++) begin
                  @(negedge Wclk);
                  chk("bp_hold", 64'(Mul_o), 64'(15));
                  chk("bp_ready", 64'(ready_o), 64'(0));
                  chk("bp_wen", 64'(Wen_o), 64'(0));
                  @(posedge Wclk); #1;
               end
               Wfull_i = 1'b0;
            end
         end
      join
      drain();
      chk("bp_writes", 64'(nwr - base), 64'(3));
      chk("bp_cnt", 64'(wr_count_o), 64'(259));

      // Bubbles: valid 1,0,1 -> writes STAGES cycles later, gap preserved
      for (int i = 0; i < ST + 4; i++) begin
         @(posedge Wclk); #1;
         valid_i = (i == 0) || (i == 2);
         a_i = (i == 0) ? 4'd2 : 4'd4;
         b_i = (i == 0) ? 4'd3 : 4'd4;
         @(negedge Wclk);
         chk("bub_wen", 64'(Wen_o), 64'((i == ST) || (i == ST + 2)));
         if (i == ST) chk("bub_p0", 64'(Mul_o), 64'(6));
         if (i == ST + 2) chk("bub_p1", 64'(Mul_o), 64'(16));
      end
      drain();

      // Random operands, random valid and random FIFO full
      pend = 0;
      repeat (400) begin
         @(posedge Wclk); #1;
         if (!pend) begin
            valid_i = ($urandom_range(0, 9) < 7);
            a_i = 4'($urandom); b_i = 4'($urandom);
         end
         Wfull_i = ($urandom_range(0, 9) < 3);
         @(negedge Wclk);
         pend = valid_i && !ready_o;
      end
      drain();
      chk("rand_cnt", 64'(wr_count_o), 64'(16'(nwr)));

      // Reset with products in flight
      send(9, 9); send(10, 11); send(12, 13);
      Wrst_n = 1'b0;
      #1;
      chk("mrst_mul", 64'(Mul_o), 64'(0));
      chk("mrst_mvld", 64'(Mul_valid_o), 64'(0));
      chk("mrst_wen", 64'(Wen_o), 64'(0));
      chk("mrst_cnt", 64'(wr_count_o), 64'(0));
      repeat (2) @(posedge Wclk);
      #1 Wrst_n = 1'b1;
      for (int k = 0; k < ST + 2; k++) begin
         @(negedge Wclk);
         chk("mrst_nowen", 64'(Wen_o), 64'(0));
      end
      @(posedge Wclk); #1;

`ifdef MUL_ACC_EN
      // Accumulator: 6, 26, then clear-then-add of 7
      send(2, 3); drain();
      chk("acc_6", 64'(Acc_o), 64'(6));
      send(4, 5); drain();
      chk("acc_26", 64'(Acc_o), 64'(26));
      hit = 0;
      fork
         send(1, 7);
         begin
            for (int k = 0; k < 20 && !hit; k++) begin
               @(posedge Wclk); #1;
               hit = Mul_valid_o && (Mul_o == 8'd7);
            end
            acc_clr_i = hit;
            @(posedge Wclk); #1;
            acc_clr_i = 1'b0;
         end
      join
      drain();
      chk("acc_7", 64'(Acc_o), 64'(7));
`endif

      // Wide instance: max operands, then counter wrap at 4 bits
      a2 = 8'd255; b2 = 6'd63; v2 = 1'b1;
      @(posedge Wclk); #1 v2 = 1'b0;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge Wclk);
         seen = mv2;
      end
      chk("w2_valid", 64'(seen), 64'(1));
      chk("w2_max", 64'(m2), 64'(16065));
      @(posedge Wclk); #1;
      repeat (16) begin
         a2 = 8'($urandom); b2 = 6'($urandom); v2 = 1'b1;
         @(posedge Wclk); #1;
      end
      v2 = 1'b0;
      repeat (ST2 + 4) @(posedge Wclk);
      #1;
      chk("w2_writes", 64'(nwr2), 64'(17));
      chk("w2_wrap", 64'(c2), 64'(1));
      chk("w2_q", 64'(q2.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
